// File: rtl/id_ex_operand_stage_pkg.sv
// ----------------------------------------------------------------------------
// id_ex_operand_stage_pkg
//   Shared widths and ALU opcodes for the ID/EX operand stage.
//   ALU_ADD doubles as the opcode loaded into a bubble, so an empty EX slot
//   still presents a harmless operation to the ALU.
// ----------------------------------------------------------------------------
package id_ex_operand_stage_pkg;

    localparam int ALU_DATA_W  = 32;  // operand / result width
    localparam int INST_ADDR_W = 32;  // pc width
    localparam int ALU_CTRL_W  = 4;   // ALU opcode width
    localparam int REG_IDX_W   = 5;   // register index width

    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR = 4'b0011;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLL = 4'b0100;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRL = 4'b0101;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 4'b0111;

endpackage

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// ----------------------------------------------------------------------------
// fwd_mux
//   Combinational 3-way forwarding select for one source register.
//   Priority: EX/MEM result, then MEM/WB result, then the registered value.
//   Index 0 is hard-wired zero in the register file and is never forwarded.
// Ports:
//   src_addr          source register index held in EX
//   reg_data          register-file value captured at ID
//   exmem_* / memwb_* writeback candidates from the later stages
//   fwd_data          selected operand
// ----------------------------------------------------------------------------
import id_ex_operand_stage_pkg::*;

module fwd_mux #(
    parameter int DATA_WIDTH     = ALU_DATA_W,
    parameter int REG_ADDR_WIDTH = REG_IDX_W
) (
    input  logic [REG_ADDR_WIDTH-1:0] src_addr,
    input  logic [DATA_WIDTH-1:0]     reg_data,
    input  logic                      exmem_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] exmem_rd_addr,
    input  logic [DATA_WIDTH-1:0]     exmem_data,
    input  logic                      memwb_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] memwb_rd_addr,
    input  logic [DATA_WIDTH-1:0]     memwb_data,
    output logic [DATA_WIDTH-1:0]     fwd_data
);

    logic hit_exmem, hit_memwb;

    assign hit_exmem = exmem_reg_write && (exmem_rd_addr != '0) && (exmem_rd_addr == src_addr);
    assign hit_memwb = memwb_reg_write && (memwb_rd_addr != '0) && (memwb_rd_addr == src_addr);

    always_comb begin
        fwd_data = reg_data;
        if (hit_exmem)      fwd_data = exmem_data;
        else if (hit_memwb) fwd_data = memwb_data;
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ----------------------------------------------------------------------------
// id_ex_operand_stage
//   ID/EX pipeline register and ALU operand producer.
//   - Captures decoded operands/controls from ID on each edge.
//   - Forwards EX/MEM and MEM/WB results onto the registered rs1/rs2 values.
//   - Detects load-use hazards: stalls ID and loads a bubble into EX.
//   - flush kills the ID->EX transfer, stall_ext freezes EX.
// Update priority per edge: rst > flush > stall_ext > load-use > capture.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   id_*                     decoded instruction from ID
//   exmem_*, memwb_*         forwarding sources
//   flush, stall_ext         branch kill, downstream stall
//   input_data_1/2, ALU_control, pc, ex_store_data  EX datapath outputs
//   ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_rd_addr  EX controls
//   id_stall                 hold PC and IF/ID this cycle
//   bubble_count, flush_count  perf counters
// Optional feature: define ID_EX_PERF_CNT_EN to build the perf counters;
// otherwise both counter ports read 0 and no counter flops exist.
// ----------------------------------------------------------------------------
import id_ex_operand_stage_pkg::*;

module id_ex_operand_stage #(
    parameter int DATA_WIDTH     = ALU_DATA_W,
    parameter int ADDR_WIDTH     = INST_ADDR_W,
    parameter int CTRL_WIDTH     = ALU_CTRL_W,
    parameter int REG_ADDR_WIDTH = REG_IDX_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [ADDR_WIDTH-1:0]     id_pc,
    input  logic [DATA_WIDTH-1:0]     id_rs1_data,
    input  logic [DATA_WIDTH-1:0]     id_rs2_data,
    input  logic [DATA_WIDTH-1:0]     id_imm,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr,
    input  logic                      id_alu_src_a,
    input  logic                      id_alu_src_b,
    input  logic [CTRL_WIDTH-1:0]     id_alu_control,
    input  logic                      id_mem_read,
    input  logic                      id_mem_write,
    input  logic                      id_reg_write,
    input  logic                      exmem_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] exmem_rd_addr,
    input  logic [DATA_WIDTH-1:0]     exmem_data,
    input  logic                      memwb_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] memwb_rd_addr,
    input  logic [DATA_WIDTH-1:0]     memwb_data,
    input  logic                      flush,
    input  logic                      stall_ext,
    output logic [DATA_WIDTH-1:0]     input_data_1,
    output logic [DATA_WIDTH-1:0]     input_data_2,
    output logic [CTRL_WIDTH-1:0]     ALU_control,
    output logic [ADDR_WIDTH-1:0]     pc,
    output logic [DATA_WIDTH-1:0]     ex_store_data,
    output logic                      ex_valid,
    output logic                      ex_mem_read,
    output logic                      ex_mem_write,
    output logic                      ex_reg_write,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
    output logic                      id_stall,
    output logic [31:0]               bubble_count,
    output logic [31:0]               flush_count
);

    typedef struct packed {
        logic                      valid;
        logic                      mem_read;
        logic                      mem_write;
        logic                      reg_write;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [REG_ADDR_WIDTH-1:0] rs1;
        logic [REG_ADDR_WIDTH-1:0] rs2;
        logic [DATA_WIDTH-1:0]     rs1_data;
        logic [DATA_WIDTH-1:0]     rs2_data;
        logic [DATA_WIDTH-1:0]     imm;
        logic                      src_a;
        logic                      src_b;
        logic [CTRL_WIDTH-1:0]     alu_ctrl;
        logic [ADDR_WIDTH-1:0]     pc;
    } ex_reg_t;

    ex_reg_t ex_q, ex_d, bubble, cap;
    logic    load_use;

    // ------------------------------------------------------------------
    // Load-use hazard: the instruction in EX is a load whose destination
    // is read by the instruction in ID. x0 never creates a dependency.
    // ------------------------------------------------------------------
    assign load_use = id_valid && ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) &&
                      ((ex_q.rd == id_rs1_addr) || (ex_q.rd == id_rs2_addr));

    assign id_stall = load_use || stall_ext;

    // ------------------------------------------------------------------
    // Next EX contents
    // A bubble clears every field (including rs addresses, pc and src
    // selects) so both ALU operands read 0 and nothing gets forwarded.
    // ------------------------------------------------------------------
    always_comb begin
        bubble          = '0;
        bubble.alu_ctrl = CTRL_WIDTH'(ALU_ADD);

        cap.valid     = id_valid;
        cap.mem_read  = id_mem_read;
        cap.mem_write = id_mem_write;
        cap.reg_write = id_reg_write;
        cap.rd        = id_rd_addr;
        cap.rs1       = id_rs1_addr;
        cap.rs2       = id_rs2_addr;
        cap.rs1_data  = id_rs1_data;
        cap.rs2_data  = id_rs2_data;
        cap.imm       = id_imm;
        cap.src_a     = id_alu_src_a;
        cap.src_b     = id_alu_src_b;
        cap.alu_ctrl  = id_alu_control;
        cap.pc        = id_pc;

        ex_d = ex_q;
        if (flush)          ex_d = bubble;
        else if (stall_ext) ex_d = ex_q;
        else if (load_use)  ex_d = bubble;
        else                ex_d = cap;
    end

    always_ff @(posedge clk) begin
        if (rst) ex_q <= bubble;
        else     ex_q <= ex_d;
    end

    // ------------------------------------------------------------------
    // Forwarding: one fwd_mux per source register (0: rs1, 1: rs2)
    // ------------------------------------------------------------------
    logic [1:0][REG_ADDR_WIDTH-1:0] src_addr;
    logic [1:0][DATA_WIDTH-1:0]     src_raw;
    logic [1:0][DATA_WIDTH-1:0]     src_fwd;

    assign src_addr = {ex_q.rs2, ex_q.rs1};
    assign src_raw  = {ex_q.rs2_data, ex_q.rs1_data};

    for (genvar g = 0; g < 2; g++) begin : g_fwd
        fwd_mux #(
            .DATA_WIDTH     (DATA_WIDTH),
            .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
        ) u_fwd (
            .src_addr        (src_addr[g]),
            .reg_data        (src_raw[g]),
            .exmem_reg_write (exmem_reg_write),
            .exmem_rd_addr   (exmem_rd_addr),
            .exmem_data      (exmem_data),
            .memwb_reg_write (memwb_reg_write),
            .memwb_rd_addr   (memwb_rd_addr),
            .memwb_data      (memwb_data),
            .fwd_data        (src_fwd[g])
        );
    end

    // ------------------------------------------------------------------
    // Operand selection and registered controls
    // ------------------------------------------------------------------
    assign input_data_1  = ex_q.src_a ? DATA_WIDTH'(ex_q.pc) : src_fwd[0];
    assign input_data_2  = ex_q.src_b ? ex_q.imm : src_fwd[1];
    assign ex_store_data = src_fwd[1];  // stores always need rs2, even when B = imm
    assign ALU_control   = ex_q.alu_ctrl;
    assign pc            = ex_q.pc;
    assign ex_valid      = ex_q.valid;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_rd_addr    = ex_q.rd;

    // ------------------------------------------------------------------
    // Perf counters
    // bubble_count: edges that load a load-use bubble (flush and stall_ext
    // take precedence, so those edges are not counted).
    // flush_count: edges where flush kills a valid ID instruction; flush
    // outranks stall_ext, so the kill is counted even during a stall.
    // ------------------------------------------------------------------
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            if (!flush && !stall_ext && load_use) bubble_cnt_q <= bubble_cnt_q + 32'd1;
            if (flush && id_valid)                flush_cnt_q  <= flush_cnt_q + 32'd1;
        end
    end

    assign bubble_count = bubble_cnt_q;
    assign flush_count  = flush_cnt_q;
`else
    assign bubble_count = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// ----------------------------------------------------------------------------
// tb_id_ex_operand_stage
//   Directed scenarios followed by randomized traffic, checked against a
//   behavioural model of the EX slot (an "instruction record" that is
//   captured, held, or replaced by an empty slot each edge).
// ----------------------------------------------------------------------------
import id_ex_operand_stage_pkg::*;

module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic        id_alu_src_a, id_alu_src_b;
    logic [3:0]  id_alu_control;
    logic        id_mem_read, id_mem_write, id_reg_write;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd_addr, memwb_rd_addr;
    logic [31:0] exmem_data, memwb_data;
    logic        flush, stall_ext;
    logic [31:0] input_data_1, input_data_2, pc, ex_store_data;
    logic [3:0]  ALU_control;
    logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;
    logic [4:0]  ex_rd_addr;
    logic        id_stall;
    logic [31:0] bubble_count, flush_count;

    id_ex_operand_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_alu_src_a(id_alu_src_a), .id_alu_src_b(id_alu_src_b),
        .id_alu_control(id_alu_control), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
        .exmem_reg_write(exmem_reg_write), .exmem_rd_addr(exmem_rd_addr),
        .exmem_data(exmem_data), .memwb_reg_write(memwb_reg_write),
        .memwb_rd_addr(memwb_rd_addr), .memwb_data(memwb_data),
        .flush(flush), .stall_ext(stall_ext),
        .input_data_1(input_data_1), .input_data_2(input_data_2),
        .ALU_control(ALU_control), .pc(pc), .ex_store_data(ex_store_data),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_rd_addr(ex_rd_addr), .id_stall(id_stall),
        .bubble_count(bubble_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model: the instruction currently sitting in EX
    // ------------------------------------------------------------------
    typedef struct {
        bit        valid, ld, st, wr, sa, sb;
        bit [4:0]  rd, rs1, rs2;
        bit [31:0] a, b, imm, ipc;
        bit [3:0]  op;
    } instr_t;

    instr_t    m_ex;
    bit [31:0] m_bubbles = 0;
    bit [31:0] m_flushes = 0;

    function automatic instr_t empty_slot();
        instr_t e;
        e = '{default: 0};
        e.op = ALU_ADD;
        return e;
    endfunction

    function automatic bit dep_on_load();
        return id_valid && m_ex.valid && m_ex.ld && m_ex.rd != 0 &&
               (m_ex.rd == id_rs1_addr || m_ex.rd == id_rs2_addr);
    endfunction

    function automatic bit [31:0] operand(input bit [4:0] r, input bit [31:0] raw);
        if (r == 0) return raw;
        if (exmem_reg_write && exmem_rd_addr == r) return exmem_data;
        if (memwb_reg_write && memwb_rd_addr == r) return memwb_data;
        return raw;
    endfunction

    initial m_ex = empty_slot();

    always @(posedge clk) begin
        if (rst) begin
            m_ex = empty_slot();
            m_bubbles = 0;
            m_flushes = 0;
        end else if (flush) begin
            if (id_valid) m_flushes = m_flushes + 1;
            m_ex = empty_slot();
        end else if (stall_ext) begin
            // EX frozen
        end else if (dep_on_load()) begin
            m_bubbles = m_bubbles + 1;
            m_ex = empty_slot();
        end else begin
            m_ex.valid = id_valid;  m_ex.ld = id_mem_read;  m_ex.st = id_mem_write;
            m_ex.wr = id_reg_write; m_ex.sa = id_alu_src_a; m_ex.sb = id_alu_src_b;
            m_ex.rd = id_rd_addr;   m_ex.rs1 = id_rs1_addr; m_ex.rs2 = id_rs2_addr;
            m_ex.a = id_rs1_data;   m_ex.b = id_rs2_data;   m_ex.imm = id_imm;
            m_ex.ipc = id_pc;       m_ex.op = id_alu_control;
        end
    end

    task automatic check_all();
        bit [31:0] r1, r2;
        r1 = operand(m_ex.rs1, m_ex.a);
        r2 = operand(m_ex.rs2, m_ex.b);
        chk("id_stall",   id_stall,      dep_on_load() || stall_ext);
        chk("in1",        input_data_1,  m_ex.sa ? m_ex.ipc : r1);
        chk("in2",        input_data_2,  m_ex.sb ? m_ex.imm : r2);
        chk("store_data", ex_store_data, r2);
        chk("alu_ctrl",   ALU_control,   m_ex.op);
        chk("pc",         pc,            m_ex.ipc);
        chk("ex_valid",   ex_valid,      m_ex.valid);
        chk("ex_ctrl",    {ex_mem_read, ex_mem_write, ex_reg_write}, {m_ex.ld, m_ex.st, m_ex.wr});
        chk("ex_rd",      ex_rd_addr,    m_ex.rd);
`ifdef ID_EX_PERF_CNT_EN
        chk("bubble_cnt", bubble_count,  m_bubbles);
        chk("flush_cnt",  flush_count,   m_flushes);
`else
        chk("bubble_cnt", bubble_count,  32'd0);
        chk("flush_cnt",  flush_count,   32'd0);
`endif
    endtask

    task automatic idle_inputs();
        rst = 0; id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
        id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0; id_alu_src_a = 0; id_alu_src_b = 0;
        id_alu_control = ALU_ADD; id_mem_read = 0; id_mem_write = 0; id_reg_write = 0;
        exmem_reg_write = 0; exmem_rd_addr = 0; exmem_data = 0;
        memwb_reg_write = 0; memwb_rd_addr = 0; memwb_data = 0;
        flush = 0; stall_ext = 0;
    endtask

    task automatic rand_inputs();
        rst             = ($urandom_range(0, 49) == 0);
        id_valid        = ($urandom_range(0, 3) != 0);
        id_pc           = $urandom & 32'hFFFF_FFFC;
        id_rs1_data     = $urandom;
        id_rs2_data     = $urandom;
        id_imm          = $urandom;
        id_rs1_addr     = 5'($urandom_range(0, 4));
        id_rs2_addr     = 5'($urandom_range(0, 4));
        id_rd_addr      = 5'($urandom_range(0, 4));
        id_alu_src_a    = ($urandom_range(0, 3) == 0);
        id_alu_src_b    = ($urandom_range(0, 1) == 0);
        id_alu_control  = 4'($urandom_range(0, 7));
        id_mem_read     = ($urandom_range(0, 2) == 0);
        id_mem_write    = ($urandom_range(0, 3) == 0);
        id_reg_write    = ($urandom_range(0, 1) == 0);
        exmem_reg_write = ($urandom_range(0, 1) == 0);
        exmem_rd_addr   = 5'($urandom_range(0, 4));
        exmem_data      = $urandom;
        memwb_reg_write = ($urandom_range(0, 1) == 0);
        memwb_rd_addr   = 5'($urandom_range(0, 4));
        memwb_data      = $urandom;
        flush           = ($urandom_range(0, 9) == 0);
        stall_ext       = ($urandom_range(0, 6) == 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
        tick();
        // reset then idle
        chk("rst ex_valid", ex_valid, 1'b0);
        chk("rst in1", input_data_1, 32'd0);
        chk("rst in2", input_data_2, 32'd0);
        chk("rst alu_ctrl", ALU_control, ALU_ADD);
        chk("rst id_stall", id_stall, 1'b0);
        check_all();

        // ADD x3, x1, x2
        id_valid = 1; id_rs1_addr = 1; id_rs2_addr = 2; id_rd_addr = 3;
        id_rs1_data = 5; id_rs2_data = 7; id_reg_write = 1; id_alu_control = ALU_ADD;
        tick();
        chk("add in1", input_data_1, 32'd5);
        chk("add in2", input_data_2, 32'd7);
        chk("add rd", ex_rd_addr, 5'd3);

        // EX/MEM beats MEM/WB on x1; then x0 destinations never forward
        id_valid = 0;
        exmem_reg_write = 1; exmem_rd_addr = 1; exmem_data = 32'h10;
        memwb_reg_write = 1; memwb_rd_addr = 1; memwb_data = 32'h20;
        #1 chk("fwd exmem prio", input_data_1, 32'h10);
        memwb_rd_addr = 0;
        #1 chk("fwd exmem only", input_data_1, 32'h10);
        exmem_rd_addr = 0; memwb_rd_addr = 1;
        #1 chk("fwd memwb", input_data_1, 32'h20);
        memwb_rd_addr = 0;
        #1 chk("fwd x0 ignored", input_data_1, 32'd5);
        check_all();
        exmem_reg_write = 0; memwb_reg_write = 0;

        // LW x4 followed by a consumer of x4
        id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_rd_addr = 4;
        id_rs1_addr = 1; id_rs2_addr = 0;
        tick();
        id_mem_read = 0; id_rs1_addr = 4; id_rs2_addr = 2; id_rd_addr = 5;
        #1 chk("lu stall", id_stall, 1'b1);
        check_all();
        tick();
        chk("lu bubble wr", ex_reg_write, 1'b0);
        chk("lu bubble vld", ex_valid, 1'b0);
        chk("lu stall clr", id_stall, 1'b0);
        check_all();
        tick();
        chk("lu dep vld", ex_valid, 1'b1);
        chk("lu dep rd", ex_rd_addr, 5'd5);

        // flush kills the valid ID instruction
        flush = 1;
        tick();
        flush = 0;
        chk("flush vld", ex_valid, 1'b0);
`ifdef ID_EX_PERF_CNT_EN
        chk("flush cnt", flush_count, 32'd1);
`endif
        check_all();

        // JAL: operand A = pc, then held through a 3-cycle downstream stall
        id_valid = 1; id_alu_src_a = 1; id_pc = 32'h100; id_rd_addr = 1;
        id_rs1_addr = 0; id_rs2_addr = 0; id_reg_write = 1;
        tick();
        chk("jal in1", input_data_1, 32'h100);
        stall_ext = 1; id_pc = 32'h200; id_rd_addr = 7; id_alu_src_a = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall in1", input_data_1, 32'h100);
            chk("stall rd", ex_rd_addr, 5'd1);
            chk("stall id_stall", id_stall, 1'b1);
        end
        check_all();
        idle_inputs();

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            tick();
            rand_inputs();
            #1 check_all();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
